// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared configuration helpers for the pipelined prefix adder
// Purpose: legality check for WIDTH/STAGES, per-stage chunk width, width ceiling.
// Ports: none (package).
package adder_pkg;

  localparam int MAX_WIDTH = 1024;

  // Legal when the carry chain splits into STAGES equal, non-empty chunks.
  function automatic bit cfg_legal(input int width, input int stages);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Guarded so an illegal STAGES value cannot divide by zero before the
  // elaboration error fires.
  function automatic int chunk_width(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - combinational Kogge-Stone adder for one chunk
// Purpose: sum = a + b + cin over W bits using a parallel-prefix carry network.
// Ports: a, b [W-1:0] operands; cin carry-in; sum [W-1:0]; cout carry out of
//        bit W-1; msb_cin carry into bit W-1 (for signed overflow).
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [W-1:0] w_half;
  logic [W-1:0] w_grp_g;
  logic [W-1:0] w_grp_p;
  logic [W-1:0] w_nxt_g;
  logic [W-1:0] w_nxt_p;
  logic [W:0]   w_carry;

  // After the last level, w_grp_g[i]/w_grp_p[i] are generate/propagate of
  // bits [i:0], so every carry depends on cin through a single AND-OR.
  always_comb begin
    w_half  = a ^ b;
    w_grp_g = a & b;
    w_grp_p = a ^ b;
    w_nxt_g = '0;
    w_nxt_p = '0;
    for (int d = 1; d < W; d = d * 2) begin
      w_nxt_g = w_grp_g;
      w_nxt_p = w_grp_p;
      for (int i = d; i < W; i++) begin
        w_nxt_g[i] = w_grp_g[i] | (w_grp_p[i] & w_grp_g[i-d]);
        w_nxt_p[i] = w_grp_p[i] & w_grp_p[i-d];
      end
      w_grp_g = w_nxt_g;
      w_grp_p = w_nxt_p;
    end
  end

  assign w_carry = {w_grp_g | (w_grp_p & {W{cin}}), cin};
  assign sum     = w_half ^ w_carry[W-1:0];
  assign cout    = w_carry[W];
  assign msb_cin = w_carry[W-1];

endmodule

// File: rtl/pipelined_prefix_adder.sv
// rtl/pipelined_prefix_adder.sv - elastic pipelined adder, one chunk per stage
// Purpose: out_sum/out_cout = in_a + in_b + in_cin, carry resolved CHUNK bits
//          per register stage, valid/ready handshake with bubble collapsing.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_a/in_b/in_cin
//        input stream; out_valid/out_ready/out_sum/out_cout output stream;
//        out_ovf signed overflow, present only when ADDER_OVF_EN is defined.
module pipelined_prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!cfg_legal(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipelined_prefix_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH <= MAX_WIDTH");
  end

  // Stage k: r_sum[k] holds sum bits [(k+1)*CHUNK-1:0] with zeros above;
  // r_a/r_b carry the operands forward so later chunks see them in step.
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_cout;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];

  logic [STAGES:0]   w_ready;
  logic [STAGES-1:0] w_vin;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cout;
  logic              w_msb_cin   [STAGES];
  logic [WIDTH-1:0]  w_a_in      [STAGES];
  logic [WIDTH-1:0]  w_b_in      [STAGES];
  logic [WIDTH-1:0]  w_sum_prev  [STAGES];
  logic [WIDTH-1:0]  w_sum_next  [STAGES];
  logic [CHUNK-1:0]  w_chunk_sum [STAGES];

  // A stage can take new data when empty or when its content moves on this
  // cycle; the chain runs combinationally from out_ready back to in_ready.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !r_valid[k] || w_ready[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_vin[k]      = in_valid;
      assign w_a_in[k]     = in_a;
      assign w_b_in[k]     = in_b;
      assign w_cin[k]      = in_cin;
      assign w_sum_prev[k] = '0;
    end else begin : g_next
      assign w_vin[k]      = r_valid[k-1];
      assign w_a_in[k]     = r_a[k-1];
      assign w_b_in[k]     = r_b[k-1];
      assign w_cin[k]      = r_cout[k-1];
      assign w_sum_prev[k] = r_sum[k-1];
    end

    adder_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .a       (w_a_in[k][k*CHUNK +: CHUNK]),
      .b       (w_b_in[k][k*CHUNK +: CHUNK]),
      .cin     (w_cin[k]),
      .sum     (w_chunk_sum[k]),
      .cout    (w_cout[k]),
      .msb_cin (w_msb_cin[k])
    );

    // Bits above the resolved chunks are always zero, so OR merges cleanly.
    assign w_sum_next[k] = w_sum_prev[k] | (WIDTH'(w_chunk_sum[k]) << (k * CHUNK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_cout  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_vin[k];
          // Bubbles leave the data registers untouched.
          if (w_vin[k]) begin
            r_sum[k]  <= w_sum_next[k];
            r_cout[k] <= w_cout[k];
            r_a[k]    <= w_a_in[k];
            r_b[k]    <= w_b_in[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[STAGES-1];
  assign out_sum   = r_sum[STAGES-1];
  assign out_cout  = r_cout[STAGES-1];

`ifdef ADDER_OVF_EN
  logic r_ovf;

  // Captured with the last stage so it stays aligned with out_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ready[STAGES-1] && w_vin[STAGES-1]) begin
      r_ovf <= w_msb_cin[STAGES-1] ^ w_cout[STAGES-1];
    end
  end

  assign out_ovf = r_ovf;
`else
  logic w_unused_msb_cin;
  assign w_unused_msb_cin = w_msb_cin[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// tb/tb_pipelined_prefix_adder.sv - directed and scoreboarded checks of the pipelined adder
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_cin, out_ready;
  logic [31:0] in_a, in_b;
  wire         in_ready, out_valid, out_cout;
  wire  [31:0] out_sum;

  logic        s7_in_valid, s7_cin, s7_out_ready;
  logic [6:0]  s7_a, s7_b;
  wire         s7_in_ready, s7_out_valid, s7_cout;
  wire  [6:0]  s7_sum;

  logic        s8_in_valid, s8_cin, s8_out_ready;
  logic [7:0]  s8_a, s8_b;
  wire         s8_in_ready, s8_out_valid, s8_cout;
  wire  [7:0]  s8_sum;

`ifdef ADDER_OVF_EN
  wire out_ovf, s7_ovf, s8_ovf;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_prefix_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADDER_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(7), .STAGES(1)) u_dut_w7 (
    .clk(clk), .rst(rst), .in_valid(s7_in_valid), .in_ready(s7_in_ready),
    .in_a(s7_a), .in_b(s7_b), .in_cin(s7_cin), .out_valid(s7_out_valid),
    .out_ready(s7_out_ready), .out_sum(s7_sum), .out_cout(s7_cout)
`ifdef ADDER_OVF_EN
    , .out_ovf(s7_ovf)
`endif
  );

  pipelined_prefix_adder #(.WIDTH(8), .STAGES(8)) u_dut_w8 (
    .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
    .in_a(s8_a), .in_b(s8_b), .in_cin(s8_cin), .out_valid(s8_out_valid),
    .out_ready(s8_out_ready), .out_sum(s8_sum), .out_cout(s8_cout)
`ifdef ADDER_OVF_EN
    , .out_ovf(s8_ovf)
`endif
  );

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      s7_in_valid = 1'b0; s7_out_ready = 1'b1;
      s8_in_valid = 1'b0; s8_out_ready = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_sum !== 32'h0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b want 0", out_cout); end
    checks++; if ({s7_out_valid, s8_out_valid} !== 2'b00) begin errors++; $display("FAIL reset_small_valid: got %b want 00", {s7_out_valid, s8_out_valid}); end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h0000_00FF; in_b = 32'h0000_0001; in_cin = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL latency_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== (i == 3)) begin errors++; $display("FAIL latency_edge%0d: out_valid got %b want %b", i + 1, out_valid, (i == 3)); end
    end
    checks++; if ({out_cout, out_sum} !== {1'b0, 32'h0000_0100}) begin errors++; $display("FAIL latency_sum: got %b/%h want 0/00000100", out_cout, out_sum); end
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          output logic [31:0] s, output logic c, output logic o, output bit to);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    to = !out_valid;
    s = out_sum;
    c = out_cout;
`ifdef ADDER_OVF_EN
    o = out_ovf;
`else
    o = 1'b0;
`endif
  endtask

  task automatic test_carry;
    logic [31:0] ta [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    logic        tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] es [4] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] s;
    logic        c, o;
    bit          to;
    for (int i = 0; i < 4; i++) begin
      send_one(ta[i], tb[i], tc[i], s, c, o, to);
      checks++; if (to) begin errors++; $display("FAIL carry%0d_timeout: no out_valid within 20 cycles", i); end
      checks++; if ({c, s} !== {ec[i], es[i]}) begin errors++; $display("FAIL carry%0d_sum: got %b/%h want %b/%h", i, c, s, ec[i], es[i]); end
`ifdef ADDER_OVF_EN
      checks++; if (o !== eo[i]) begin errors++; $display("FAIL carry%0d_ovf: got %b want %b", i, o, eo[i]); end
`else
      if (o !== 1'b0 && eo[i] === 1'b1) $display("carry%0d: overflow not built", i);
`endif
    end
  endtask

  task automatic run_stream(input int n, input int vpct, input int rpct, output int cyc);
    logic [32:0] exp_q [$];
    logic [32:0] e;
    int          sent = 0;
    int          got = 0;
    logic        held_v = 1'b0;
    logic [32:0] held = '0;
    cyc = 0;
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        checks++;
        if ({out_valid, out_cout, out_sum} !== {1'b1, held}) begin
          errors++; $display("FAIL stall_hold: got v=%b %b/%h want v=1 %b/%h", out_valid, out_cout, out_sum, held[32], held[31:0]);
        end
      end
      in_valid  = (sent < n) && ($urandom_range(99) < vpct);
      in_a      = $urandom;
      in_b      = $urandom;
      in_cin    = 1'($urandom_range(1));
      out_ready = ($urandom_range(99) < rpct);
      #1;
      if (rpct == 100) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1 (cycle %0d)", in_ready, cyc); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: unexpected result %b/%h", out_cout, out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_cout, out_sum} !== e) begin errors++; $display("FAIL stream_word%0d: got %b/%h want %b/%h", got, out_cout, out_sum, e[32], e[31:0]); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + {32'b0, in_cin});
        sent++;
      end
      held_v = out_valid && !out_ready;
      held   = {out_cout, out_sum};
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != n) begin errors++; $display("FAIL stream_count: got %0d results want %0d", got, n); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    run_stream(100, 100, 100, cyc);
    checks++; if (cyc != 104) begin errors++; $display("FAIL b2b_cycles: took %0d cycles want 104", cyc); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ba [6] = '{32'h0000_0001, 32'h8000_0000, 32'h1234_5678, 32'h0000_FFFF, 32'hAAAA_AAAA, 32'h5555_5555};
    logic [31:0] bb [6] = '{32'h0000_0001, 32'h8000_0000, 32'h1111_1111, 32'h0000_0001, 32'h1, 32'h1};
    logic        bc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] es [4] = '{32'h0000_0002, 32'h0000_0000, 32'h2345_678A, 32'h0001_0000};
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      in_valid = (idx < 6);
      if (idx < 6) begin in_a = ba[idx]; in_b = bb[idx]; in_cin = bc[idx]; end
      out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== (c < 4)) begin errors++; $display("FAIL bp_in_ready_c%0d: got %b want %b", c, in_ready, (c < 4)); end
      if (in_valid && in_ready) idx++;
    end
    checks++; if (idx != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", idx); end
    checks++; if ({out_valid, out_cout, out_sum} !== {1'b1, ec[0], es[0]}) begin errors++; $display("FAIL bp_hold: got v=%b %b/%h want v=1 %b/%h", out_valid, out_cout, out_sum, ec[0], es[0]); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_cout, out_sum} !== {1'b1, ec[i], es[i]}) begin errors++; $display("FAIL bp_drain%0d: got v=%b %b/%h want v=1 %b/%h", i, out_valid, out_cout, out_sum, ec[i], es[i]); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_random_stall;
    int cyc;
    run_stream(1000, 50, 50, cyc);
  endtask

  task automatic test_small_configs;
    @(negedge clk);
    s7_in_valid = 1'b1; s7_a = 7'h7F; s7_b = 7'h01; s7_cin = 1'b1; s7_out_ready = 1'b0;
    s8_in_valid = 1'b1; s8_a = 8'hFF; s8_b = 8'h00; s8_cin = 1'b1; s8_out_ready = 1'b1;
    #1;
    checks++; if ({s7_in_ready, s8_in_ready} !== 2'b11) begin errors++; $display("FAIL small_in_ready: got %b want 11", {s7_in_ready, s8_in_ready}); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s7_in_valid = 1'b0; s8_in_valid = 1'b0;
      checks++; if ({s7_out_valid, s7_cout, s7_sum} !== {1'b1, 1'b1, 7'h01}) begin errors++; $display("FAIL w7_hold_c%0d: got v=%b %b/%h want v=1 1/01", i, s7_out_valid, s7_cout, s7_sum); end
      checks++; if (s8_out_valid !== (i == 7)) begin errors++; $display("FAIL w8_latency_c%0d: out_valid got %b want %b", i, s8_out_valid, (i == 7)); end
    end
    checks++; if ({s8_cout, s8_sum} !== {1'b1, 8'h00}) begin errors++; $display("FAIL w8_sum: got %b/%h want 1/00", s8_cout, s8_sum); end
    s7_in_valid = 1'b1; s7_a = 7'h15; s7_b = 7'h2A; s7_cin = 1'b0; s7_out_ready = 1'b1;
    #1;
    checks++; if (s7_in_ready !== 1'b1) begin errors++; $display("FAIL w7_full_in_ready: got %b want 1", s7_in_ready); end
    @(negedge clk);
    s7_in_valid = 1'b0;
    checks++; if ({s7_out_valid, s7_cout, s7_sum} !== {1'b1, 1'b0, 7'h3F}) begin errors++; $display("FAIL w7_next: got v=%b %b/%h want v=1 0/3f", s7_out_valid, s7_cout, s7_sum); end
  endtask

  task automatic test_reset_inflight;
    logic seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b0; s7_out_ready = 1'b0; s8_out_ready = 1'b1;
      in_valid = (i < 3); in_a = 32'(i + 1); in_b = 32'h10; in_cin = 1'b0;
      s8_in_valid = (i < 3); s8_a = 8'(i + 1); s8_b = 8'h20; s8_cin = 1'b0;
      s7_in_valid = (i == 0); s7_a = 7'h03; s7_b = 7'h04; s7_cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; s7_in_valid = 1'b0; s8_in_valid = 1'b0;
    #1;
    checks++; if ({out_valid, s7_out_valid} !== 2'b11) begin errors++; $display("FAIL rst_pre_valid: got %b want 11", {out_valid, s7_out_valid}); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_cout, out_sum} !== 34'h0) begin errors++; $display("FAIL rst_async_main: got v=%b %b/%h want all 0", out_valid, out_cout, out_sum); end
    checks++; if ({s7_out_valid, s7_sum, s8_out_valid} !== 9'h0) begin errors++; $display("FAIL rst_async_small: got %b/%h/%b want all 0", s7_out_valid, s7_sum, s8_out_valid); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; s7_out_ready = 1'b1; s8_out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid || s7_out_valid || s8_out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_stale: result seen after reset"); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    s7_in_valid = 1'b0; s7_a = '0; s7_b = '0; s7_cin = 1'b0; s7_out_ready = 1'b1;
    s8_in_valid = 1'b0; s8_a = '0; s8_b = '0; s8_cin = 1'b0; s8_out_ready = 1'b1;
    test_reset();
    idle(2);
    test_latency();
    idle(2);
    test_carry();
    idle(2);
    test_back_to_back();
    idle(2);
    test_backpressure();
    idle(2);
    test_random_stall();
    idle(2);
    test_small_configs();
    idle(3);
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached after %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_prefix_adder.md
Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined successor to the team's combinational prefix adder. Adds two WIDTH-bit operands plus a carry-in. The carry chain is split into STAGES equal chunks, and one chunk is resolved per register stage. Sits between producer and consumer blocks on a valid/ready stream, sustaining one addition per cycle with full backpressure support.

Parameters:
WIDTH, 32, operand/sum width in bits; must be >= 1.
STAGES, 4, number of pipeline register stages (= chunks); 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0, else elaboration error.
CHUNK (localparam), WIDTH/STAGES, bits resolved per stage.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand word valid.
in_ready  output  1  block can accept operands this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry-in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
out_cout  output  1  carry-out of bit WIDTH-1.

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high. While rst=1, every stage valid bit, data register and output is 0: out_valid=0, out_sum=0, out_cout=0.
- Stage k (0..STAGES-1) holds the following:
  - valid_k.
  - Sum bits [(k+1)*CHUNK-1:0].
  - Carry out of chunk k.
  - Unconsumed operand bits of chunks k+1..STAGES-1 (skew registers).
- Stage 0 loads on the input handshake. It adds chunk 0 of in_a/in_b with in_cin.
- Stage k>0 adds chunk k of its forwarded operands with stage k-1's carry.
- The chunk add is a combinational generate/propagate prefix network (Kogge-Stone style), not a ripple chain.
- Handshake is elastic and bubble-collapsing:
  - ready_STAGES = out_ready.
  - ready_k = !valid_k || ready_{k+1}.
  - in_ready = ready_0. This is a combinational path from out_ready to in_ready, and it is intentional.
  - Stage k captures when ready_k=1. It captures valid from the previous stage (or in_valid for k=0), and data only when the incoming valid is 1.
- out_valid = valid_{STAGES-1}. out_sum/out_cout come directly from the last-stage registers.
- Latency: a transfer accepted at edge T shows out_valid=1 after edge T+STAGES-1 (STAGES register stages), provided there is no stall. Throughput is 1 result/cycle.
- Stall (out_ready=0 with out_valid=1): the last stage holds. Upstream stages keep filling bubbles until all are full, then in_ready=0. No data is lost or duplicated. Results come out in acceptance order.
- out_valid=1 with out_ready=0: out_sum/out_cout stay stable until accepted.
- Simultaneous accept and deliver on a full pipe: all stages advance in the same cycle and in_ready stays 1.
- in_valid=0: a bubble propagates. Data registers need not update.
- Wrap-around: the sum is mod 2^WIDTH, and the carry is reported only on out_cout.
- Reset mid-operation: all in-flight words are discarded and nothing is emitted afterwards.
- STAGES=1 degenerates to a single registered full-width prefix adder.

Optional Feature:
- Macro ADDER_OVF_EN.
- When defined: adds output port out_ovf (1 bit). It is the registered two's-complement signed overflow: carry into MSB XOR carry out of MSB. It is aligned with out_sum, resets to 0, and holds under stall like out_sum.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package adder_pkg:
  - Function that checks WIDTH/STAGES legality.
  - Function computing CHUNK.
  - Localparam for the maximum supported WIDTH (1024).
- Sub-module adder_chunk: purely combinational, parameter W. It takes a, b and cin, and produces sum, cout and msb_cin (used for overflow).
- Top-level instances: one adder_chunk per stage via generate, plus the stage registers and handshake logic.

Test Plan:
- Config WIDTH=32, STAGES=4, always ready. Send a=0x0000_00FF, b=0x0000_0001, cin=0 -> out_sum=0x0000_0100, out_cout=0, out_valid exactly 4 edges after acceptance.
- Carry ripple across all chunks: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> out_sum=0, out_cout=1. With ADDER_OVF_EN: out_ovf=0. For a=0x7FFF_FFFF, b=1 -> out_ovf=1.
- Back-to-back stream of 100 random operands with out_ready=1 -> one result per cycle, in order, matching a reference model.
- Backpressure:
  - Send 6 words while out_ready=0 -> in_ready falls after 4 accepted, and out_sum holds the first result.
  - Release out_ready -> all 4 results drain in order, and in_ready rises the same cycle out_ready rises.
- Random in_valid/out_ready toggling (50% each, 1000 words) -> no loss, no duplication, order preserved, outputs stable while stalled.
- Assert rst with 3 words in flight -> out_valid=0 and out_sum=0 immediately, and no stale results after rst deasserts. Repeat with WIDTH=7, STAGES=1 and WIDTH=8, STAGES=8.
